// File: rtl/divider_pipe.sv
// divider_pipe: streaming restoring divider, one quotient/remainder per clock.
// Signed or unsigned operands; BITS_PER_STAGE restoring steps per pipeline register.
module divider_pipe #(
  parameter int DIVIDEND_WIDTH = 32,
  parameter int DIVISOR_WIDTH  = 24,
  parameter int BITS_PER_STAGE = 1,
  parameter bit SIGNED         = 1'b1,
  parameter int TAG_WIDTH      = 8
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  input  logic                      ivalid,
  input  logic [TAG_WIDTH-1:0]      itag,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div_by_zero,
  output logic [TAG_WIDTH-1:0]      otag,
  output logic                      ovalid
);
  localparam int DW = DIVIDEND_WIDTH;
  localparam int VW = DIVISOR_WIDTH;
  localparam int N  = DIVIDEND_WIDTH / BITS_PER_STAGE;

  if (DW % BITS_PER_STAGE != 0) begin : g_bad_bps
    $error("divider_pipe: BITS_PER_STAGE must divide DIVIDEND_WIDTH");
  end
  if (VW < 2 || VW > DW) begin : g_bad_vw
    $error("divider_pipe: DIVISOR_WIDTH must be in [2, DIVIDEND_WIDTH]");
  end

  // One restoring step; the shifted remainder keeps an extra top bit so a
  // full-width unsigned divisor cannot overflow the compare.
  function automatic logic [2*DW-1:0] restore_step(input logic [2*DW-1:0] r,
                                                   input logic [VW-1:0]   d);
    logic [2*DW:0] sh;
    logic [DW:0]   hi;
    logic [DW:0]   dext;
    dext          = '0;
    dext[VW-1:0]  = d;
    sh            = {r, 1'b0};
    hi            = sh[2*DW:DW];
    if (hi >= dext) begin
      hi    = hi - dext;
      sh[0] = 1'b1;
    end
    return {hi[DW-1:0], sh[DW-1:0]};
  endfunction

  logic          dvd_neg, dvs_neg;
  logic [DW-1:0] dvd_mag;
  logic [VW-1:0] dvs_mag;

  always_comb begin
    dvd_neg = SIGNED && dividend[DW-1];
    dvs_neg = SIGNED && divisor[VW-1];
    dvd_mag = dvd_neg ? -dividend : dividend;
    dvs_mag = dvs_neg ? -divisor : divisor;
  end

  logic [2*DW-1:0]      rem_q [0:N];
  logic [VW-1:0]        dvs_q [0:N];
  logic [TAG_WIDTH-1:0] tag_q [0:N];
  logic [N:0]           qs_q, rs_q, dz_q, vld_q;
  logic [2*DW-1:0]      rem_d [0:N-1];

  always_comb begin
    for (int s = 0; s < N; s++) begin
      rem_d[s] = rem_q[s];
      for (int b = 0; b < BITS_PER_STAGE; b++) begin
        rem_d[s] = restore_step(rem_d[s], dvs_q[s]);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      for (int s = 0; s <= N; s++) begin
        rem_q[s] <= '0;
        dvs_q[s] <= '0;
        tag_q[s] <= '0;
      end
      qs_q  <= '0;
      rs_q  <= '0;
      dz_q  <= '0;
      vld_q <= '0;
    end else begin
      rem_q[0] <= {{DW{1'b0}}, dvd_mag};
      dvs_q[0] <= dvs_mag;
      tag_q[0] <= itag;
      qs_q[0]  <= dvd_neg ^ dvs_neg;
      rs_q[0]  <= dvd_neg;
      dz_q[0]  <= (divisor == '0);
      vld_q[0] <= ivalid;
      for (int s = 1; s <= N; s++) begin
        rem_q[s] <= rem_d[s-1];
        dvs_q[s] <= dvs_q[s-1];
        tag_q[s] <= tag_q[s-1];
      end
      qs_q[N:1]  <= qs_q[N-1:0];
      rs_q[N:1]  <= rs_q[N-1:0];
      dz_q[N:1]  <= dz_q[N-1:0];
      vld_q[N:1] <= vld_q[N-1:0];
    end
  end

  logic [DW-1:0] q_mag, quo_d;
  logic [VW-1:0] r_mag, rem_out_d;

  always_comb begin
    q_mag     = rem_q[N][DW-1:0];
    r_mag     = rem_q[N][DW+VW-1:DW];
    quo_d     = qs_q[N] ? -q_mag : q_mag;
    rem_out_d = rs_q[N] ? -r_mag : r_mag;
    // Divide by zero saturates toward the dividend's sign.
    if (dz_q[N]) begin
      rem_out_d = '0;
      if (!SIGNED) quo_d = '1;
      else         quo_d = {rs_q[N], {(DW-1){!rs_q[N]}}};
    end
  end

  logic [DW-1:0]        quotient_q;
  logic [VW-1:0]        remainder_q;
  logic                 dbz_q, ovalid_q;
  logic [TAG_WIDTH-1:0] otag_q;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      otag_q      <= '0;
      ovalid_q    <= 1'b0;
    end else begin
      ovalid_q <= vld_q[N];
      if (vld_q[N]) begin
        quotient_q  <= quo_d;
        remainder_q <= rem_out_d;
        dbz_q       <= dz_q[N];
        otag_q      <= tag_q[N];
      end
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign otag        = otag_q;
  assign ovalid      = ovalid_q;

endmodule
